// File: rtl/lockstep_divergence_monitor_if.sv
// Probe bundle that carries the ROB enqueue and commit streams of the DUT
// and variant harnesses into the lockstep divergence monitor.
interface lockstep_divergence_monitor_if #(
    parameter int LANES  = 2,
    parameter int INST_W = 32
);
    logic [LANES-1:0]        dut_enq_valid;
    logic [LANES*INST_W-1:0] dut_enq_inst;
    logic [LANES-1:0]        vnt_enq_valid;
    logic [LANES*INST_W-1:0] vnt_enq_inst;
    logic [LANES-1:0]        dut_cmt_valid;
    logic [LANES*INST_W-1:0] dut_cmt_inst;
    logic [LANES-1:0]        vnt_cmt_valid;
    logic [LANES*INST_W-1:0] vnt_cmt_inst;

    modport master (
        output dut_enq_valid, dut_enq_inst, vnt_enq_valid, vnt_enq_inst,
        output dut_cmt_valid, dut_cmt_inst, vnt_cmt_valid, vnt_cmt_inst
    );

    modport slave (
        input dut_enq_valid, dut_enq_inst, vnt_enq_valid, vnt_enq_inst,
        input dut_cmt_valid, dut_cmt_inst, vnt_cmt_valid, vnt_cmt_inst
    );
endinterface

// File: rtl/lockstep_divergence_monitor.sv
// Compares DUT and variant ROB enqueue streams lane by lane, latches the first
// divergence, then waits for both sides to commit the end-of-test marker.
module lockstep_divergence_monitor #(
    parameter int                LANES     = 2,
    parameter int                INST_W    = 32,
    parameter logic [INST_W-1:0] DONE_INST = 32'h00302013,
    parameter int                TIMEOUT   = 4096,
    parameter int                CNT_W     = 32,
    localparam int               LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    lockstep_divergence_monitor_if.slave  probe,
    output logic                          sync,
    output logic [1:0]                    state,
    output logic                          dut_done,
    output logic                          vnt_done,
    output logic [LANE_W-1:0]             div_lane,
    output logic [CNT_W-1:0]              div_cycle
);
    typedef enum logic [1:0] {
        ST_SYNC     = 2'd0,
        ST_DIVERGED = 2'd1,
        ST_DONE     = 2'd2,
        ST_TIMEOUT  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  div_cycle_q, div_cycle_d;
    logic [LANE_W-1:0] div_lane_q, div_lane_d;
    logic              dut_done_q, dut_done_d;
    logic              vnt_done_q, vnt_done_d;

    logic [LANES-1:0]  mismatch;
    logic [LANE_W-1:0] first_lane;
    logic              dut_hit, vnt_hit, both_next;

    // Instruction bits only matter on a lane where both sides enqueue.
    always_comb begin : lane_compare
        mismatch   = '0;
        first_lane = '0;
        dut_hit    = 1'b0;
        vnt_hit    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            mismatch[i] = (probe.dut_enq_valid[i] != probe.vnt_enq_valid[i]) ||
                          (probe.dut_enq_valid[i] &&
                           (probe.dut_enq_inst[i*INST_W +: INST_W] !=
                            probe.vnt_enq_inst[i*INST_W +: INST_W]));
            dut_hit = dut_hit | (probe.dut_cmt_valid[i] &&
                                 (probe.dut_cmt_inst[i*INST_W +: INST_W] == DONE_INST));
            vnt_hit = vnt_hit | (probe.vnt_cmt_valid[i] &&
                                 (probe.vnt_cmt_inst[i*INST_W +: INST_W] == DONE_INST));
        end
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mismatch[i]) first_lane = LANE_W'(i);
        end
        both_next = (dut_done_q | dut_hit) & (vnt_done_q | vnt_hit);
    end

    always_ff @(posedge clock or negedge reset) begin : state_reg
        if (!reset) state_q <= ST_SYNC;
        else        state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin : data_reg
        if (!reset) begin
            cycle_q     <= '0;
            tmo_q       <= '0;
            div_cycle_q <= '0;
            div_lane_q  <= '0;
            dut_done_q  <= 1'b0;
            vnt_done_q  <= 1'b0;
        end else begin
            cycle_q     <= cycle_d;
            tmo_q       <= tmo_d;
            div_cycle_q <= div_cycle_d;
            div_lane_q  <= div_lane_d;
            dut_done_q  <= dut_done_d;
            vnt_done_q  <= vnt_done_d;
        end
    end

    // A marker landing on the timeout edge still completes the run one edge later.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_SYNC: begin
                if (|mismatch) state_d = ST_DIVERGED;
            end
            ST_DIVERGED: begin
                if (dut_done_q && vnt_done_q)                  state_d = ST_DONE;
                else if ((tmo_q == TMO_LAST) && !both_next)    state_d = ST_TIMEOUT;
            end
            default: state_d = state_q;
        endcase
        if (clear) state_d = ST_SYNC;
    end

    always_comb begin : datapath_next
        cycle_d     = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
        tmo_d       = tmo_q;
        div_cycle_d = div_cycle_q;
        div_lane_d  = div_lane_q;
        dut_done_d  = dut_done_q;
        vnt_done_d  = vnt_done_q;
        case (state_q)
            ST_SYNC: begin
                if (|mismatch) begin
                    div_lane_d  = first_lane;
                    div_cycle_d = cycle_q;
                    tmo_d       = '0;
                end
            end
            ST_DIVERGED: begin
                dut_done_d = dut_done_q | dut_hit;
                vnt_done_d = vnt_done_q | vnt_hit;
                if (tmo_q != '1) tmo_d = tmo_q + CNT_W'(1);
            end
            default: ;
        endcase
        if (clear) begin
            tmo_d       = '0;
            div_cycle_d = '0;
            div_lane_d  = '0;
            dut_done_d  = 1'b0;
            vnt_done_d  = 1'b0;
        end
    end

    always_comb begin : outputs
        sync      = (state_q == ST_SYNC);
        state     = state_q;
        dut_done  = dut_done_q;
        vnt_done  = vnt_done_q;
        div_lane  = div_lane_q;
        div_cycle = div_cycle_q;
    end
endmodule
